// File: rtl/fp_seq_alu_pkg.sv
// Shared opcodes, status bit positions, FSM states and helpers for the
// sequential host-side arithmetic engine.
package fp_seq_alu_pkg;

  localparam int unsigned OP_W   = 3;
  localparam int unsigned STAT_W = 16;
  localparam int unsigned CTRL_W = 16;

  localparam logic [OP_W-1:0] OP_ADD    = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB    = 3'd1;
  localparam logic [OP_W-1:0] OP_MUL    = 3'd2;
  localparam logic [OP_W-1:0] OP_DIV    = 3'd3;
  localparam logic [OP_W-1:0] OP_MAC    = 3'd4;
  localparam logic [OP_W-1:0] OP_CLRACC = 3'd5;

  localparam int unsigned CTRL_CLR_BIT = 8;

  localparam int unsigned ST_CARRY = 0;
  localparam int unsigned ST_ZERO  = 1;
  localparam int unsigned ST_DIVZ  = 2;
  localparam int unsigned ST_ILL   = 3;
  localparam int unsigned ST_OVR   = 4;
  localparam int unsigned ST_BUSY  = 5;
  localparam int unsigned ST_CNT   = 8;
  localparam int unsigned ST_CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic ill;
    logic dz;
    logic zero;
    logic carry;
  } flags_t;

  // Opcodes that need the iterative shift-add / restoring-divide unit
  function automatic logic is_iter(input logic [OP_W-1:0] opc);
    return (opc == OP_MUL) || (opc == OP_DIV) || (opc == OP_MAC);
  endfunction

endpackage

// File: rtl/fp_seq_alu_if.sv
// Host-facing bundle: WireIn operands/control in, WireOut result/status out.
interface fp_seq_alu_if #(
  parameter int unsigned DATA_W = 16
);
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [15:0]       ctrl;
  logic              start;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result_lo;
  logic [DATA_W-1:0] result_hi;
  logic [15:0]       status;

  modport master (
    output op_a, op_b, ctrl, start,
    input  busy, done, result_lo, result_hi, status
  );

  modport slave (
    input  op_a, op_b, ctrl, start,
    output busy, done, result_lo, result_hi, status
  );
endinterface

// File: rtl/seq_muldiv_unit.sv
// Iterative DATA_W-step unsigned shift-add multiplier and restoring divider.
// load captures operands; one step per cycle afterwards.
module seq_muldiv_unit #(
  parameter int unsigned DATA_W = 16
) (
  input  logic                ti_clk,
  input  logic                reset,
  input  logic                load,
  input  logic                div,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic                step_done_c,
  output logic [2*DATA_W-1:0] product,
  output logic [DATA_W-1:0]   quotient,
  output logic [DATA_W-1:0]   remainder
);

  localparam int unsigned ITER_W = $clog2(DATA_W + 1);

  logic [ITER_W-1:0] iter_q;
  logic              div_q;
  logic [DATA_W-1:0] opnd_q;
  logic [DATA_W:0]   part_c;
  logic [DATA_W:0]   shl_c;
  logic [DATA_W:0]   trial_c;

  always_comb begin
    part_c  = {1'b0, product[2*DATA_W-1:DATA_W]} + {1'b0, opnd_q};
    shl_c   = {remainder, quotient[DATA_W-1]};
    trial_c = shl_c - {1'b0, opnd_q};
  end

  // Flags the step that completes the operation
  assign step_done_c = (iter_q == ITER_W'(1));

  always_ff @(posedge ti_clk or posedge reset) begin
    if (reset) begin
      iter_q    <= '0;
      div_q     <= 1'b0;
      opnd_q    <= '0;
      product   <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (load) begin
      iter_q    <= ITER_W'(DATA_W);
      div_q     <= div;
      opnd_q    <= div ? b : a;
      product   <= {DATA_W'(0), b};
      quotient  <= a;
      remainder <= '0;
    end else if (iter_q != '0) begin
      iter_q <= iter_q - ITER_W'(1);
      if (div_q) begin
        // Top bit of the trial difference set means the divisor did not fit
        if (!trial_c[DATA_W]) begin
          remainder <= trial_c[DATA_W-1:0];
          quotient  <= {quotient[DATA_W-2:0], 1'b1};
        end else begin
          remainder <= shl_c[DATA_W-1:0];
          quotient  <= {quotient[DATA_W-2:0], 1'b0};
        end
      end else if (product[0]) begin
        product <= {part_c, product[DATA_W-1:1]};
      end else begin
        product <= {1'b0, product[2*DATA_W-1:1]};
      end
    end
  end

endmodule

// File: rtl/fp_seq_alu.sv
// Host-driven sequential ALU: add/sub/mul/div/mac with accumulator,
// sticky overrun, status flags and a completed-operation counter.
module fp_seq_alu
  import fp_seq_alu_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 8
) (
  input  logic         ti_clk,
  input  logic         reset,
  fp_seq_alu_if.slave  bus
);

  localparam int unsigned RES_W = 2 * DATA_W;

  state_e            state;
  state_e            state_nx;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [OP_W-1:0]   opc_q;
  logic [RES_W-1:0]  acc_q;
  logic [RES_W-1:0]  res_q;
  flags_t            flags_q;
  logic              ovr_q;
  logic              busy_q;
  logic              done_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              accept_c;
  logic [OP_W-1:0]   opc_in_c;
  logic              step_done_c;
  logic [RES_W-1:0]  product;
  logic [DATA_W-1:0] quotient;
  logic [DATA_W-1:0] remainder;

  logic [DATA_W:0]   sum_c;
  logic [DATA_W:0]   diff_c;
  logic [RES_W:0]    mac_c;
  logic [RES_W-1:0]  res_c;
  logic [RES_W-1:0]  acc_nx_c;
  flags_t            flags_c;
  logic [STAT_W-1:0] status_c;
  logic              ctrl_unused_c;

  assign opc_in_c      = bus.ctrl[OP_W-1:0];
  assign accept_c      = bus.start && !busy_q;
  assign ctrl_unused_c = ^{bus.ctrl[15:9], bus.ctrl[7:3]};

  seq_muldiv_unit #(.DATA_W(DATA_W)) u_muldiv (
    .ti_clk      (ti_clk),
    .reset       (reset),
    .load        (accept_c),
    .div         (opc_in_c == OP_DIV),
    .a           (bus.op_a),
    .b           (bus.op_b),
    .step_done_c (step_done_c),
    .product     (product),
    .quotient    (quotient),
    .remainder   (remainder)
  );

  always_ff @(posedge ti_clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Divide by zero resolves without iterating
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept_c) begin
        if (is_iter(opc_in_c) && !((opc_in_c == OP_DIV) && (bus.op_b == '0)))
          state_nx = S_RUN;
        else
          state_nx = S_DONE;
      end
      S_RUN:   if (step_done_c) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Result and flag selection from the latched command
  always_comb begin
    sum_c    = {1'b0, a_q} + {1'b0, b_q};
    diff_c   = {1'b0, a_q} - {1'b0, b_q};
    mac_c    = {1'b0, acc_q} + {1'b0, product};
    res_c    = res_q;
    acc_nx_c = acc_q;
    flags_c  = '0;
    case (opc_q)
      OP_ADD: begin
        res_c         = RES_W'(sum_c[DATA_W-1:0]);
        flags_c.carry = sum_c[DATA_W];
      end
      OP_SUB: begin
        res_c         = RES_W'(diff_c[DATA_W-1:0]);
        flags_c.carry = diff_c[DATA_W];
      end
      OP_MUL: res_c = product;
      OP_DIV: begin
        if (b_q == '0) begin
          res_c      = {a_q, {DATA_W{1'b1}}};
          flags_c.dz = 1'b1;
        end else begin
          res_c = {remainder, quotient};
        end
      end
      OP_MAC: begin
        acc_nx_c      = mac_c[RES_W-1:0];
        res_c         = mac_c[RES_W-1:0];
        flags_c.carry = mac_c[RES_W];
      end
      OP_CLRACC: begin
        acc_nx_c = '0;
        res_c    = '0;
      end
      default: flags_c.ill = 1'b1;
    endcase
    flags_c.zero = (res_c == '0);
  end

  always_ff @(posedge ti_clk or posedge reset) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      opc_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      busy_q <= accept_c || (state != S_IDLE);
      if (accept_c) begin
        a_q   <= bus.op_a;
        b_q   <= bus.op_b;
        opc_q <= opc_in_c;
        if (bus.ctrl[CTRL_CLR_BIT]) ovr_q <= 1'b0;
      end else if (bus.start) begin
        ovr_q <= 1'b1;
      end
      if (state == S_DONE) begin
        res_q   <= res_c;
        acc_q   <= acc_nx_c;
        flags_q <= flags_c;
        cnt_q   <= cnt_q + CNT_W'(1);
        done_q  <= 1'b1;
      end
    end
  end

  always_comb begin
    status_c                      = '0;
    status_c[ST_CARRY]            = flags_q.carry;
    status_c[ST_ZERO]             = flags_q.zero;
    status_c[ST_DIVZ]             = flags_q.dz;
    status_c[ST_ILL]              = flags_q.ill;
    status_c[ST_OVR]              = ovr_q;
    status_c[ST_BUSY]             = busy_q;
    status_c[ST_CNT +: ST_CNT_W]  = ST_CNT_W'(cnt_q);
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result_lo = res_q[DATA_W-1:0];
  assign bus.result_hi = res_q[RES_W-1:DATA_W];
  assign bus.status    = status_c;

endmodule
